// File: rtl/smi_frame_arbiter_x2.sv
// Two-input SMI frame arbiter: round-robin at frame granularity, merged into a
// 2-entry output FIFO with registered valid.
module smi_frame_arbiter_x2 #(
   parameter int FlitWidth = 16,
   parameter int EofcMask  = 2*FlitWidth-1
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   smiInAReady,
   input  logic [7:0]             smiInAEofc,
   input  logic [FlitWidth*8-1:0] smiInAData,
   output logic                   smiInAStop,
   input  logic                   smiInBReady,
   input  logic [7:0]             smiInBEofc,
   input  logic [FlitWidth*8-1:0] smiInBData,
   output logic                   smiInBStop,
   output logic                   smiOutReady,
   output logic [7:0]             smiOutEofc,
   output logic [FlitWidth*8-1:0] smiOutData,
   input  logic                   smiOutStop
);

   localparam int         DW        = FlitWidth*8;
   localparam logic [7:0] EOFC_MASK = 8'(EofcMask);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          rr_b_q, rr_b_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic          out_ready_q, out_ready_d;
   logic [DW-1:0] data_mem_q [2];
   logic [7:0]    eofc_mem_q [2];

   logic          grant_a_s, grant_b_s;
   logic          rd_s, blocked_s;
   logic          acc_a_s, acc_b_s, wr_s, last_s;
   logic [7:0]    wr_eofc_s;
   logic [DW-1:0] wr_data_s;

   // Grant eligibility; in IDLE each side's grant looks only at the other
   // side's Ready so that a Stop never depends on its own Ready.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      case (state_q)
         IDLE: begin
            grant_a_s = !rr_b_q || !smiInBReady;
            grant_b_s =  rr_b_q || !smiInAReady;
         end
         LOCK_A:  grant_a_s = 1'b1;
         LOCK_B:  grant_b_s = 1'b1;
         default: begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
         end
      endcase
   end

   assign rd_s       = out_ready_q && !smiOutStop;
   assign blocked_s  = (cnt_q == 2'd2) && !rd_s;
   assign smiInAStop = srst || !grant_a_s || blocked_s;
   assign smiInBStop = srst || !grant_b_s || blocked_s;
   assign acc_a_s    = smiInAReady && !smiInAStop;
   assign acc_b_s    = smiInBReady && !smiInBStop;
   assign wr_s       = acc_a_s || acc_b_s;
   assign wr_eofc_s  = acc_a_s ? smiInAEofc : smiInBEofc;
   assign wr_data_s  = acc_a_s ? smiInAData : smiInBData;
   assign last_s     = (wr_eofc_s != 8'd0);

   // Next-state for the frame lock, round-robin pointer and FIFO bookkeeping.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (acc_a_s && !last_s) begin
               state_d = LOCK_A;
            end else if (acc_b_s && !last_s) begin
               state_d = LOCK_B;
            end else begin
               state_d = IDLE;
            end
         end
         LOCK_A: begin
            if (acc_a_s && last_s) begin
               state_d = IDLE;
            end else begin
               state_d = LOCK_A;
            end
         end
         LOCK_B: begin
            if (acc_b_s && last_s) begin
               state_d = IDLE;
            end else begin
               state_d = LOCK_B;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_s && last_s) begin
         rr_b_d = !rr_b_q;
      end else begin
         rr_b_d = rr_b_q;
      end

      cnt_d       = cnt_q + {1'b0, wr_s} - {1'b0, rd_s};
      wr_ptr_d    = wr_ptr_q ^ wr_s;
      rd_ptr_d    = rd_ptr_q ^ rd_s;
      out_ready_d = (cnt_d != 2'd0);
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= IDLE;
         rr_b_q      <= 1'b0;
         cnt_q       <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         out_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_b_q      <= rr_b_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_ready_q <= out_ready_d;
      end
   end

   // Flit storage; contents are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         data_mem_q[wr_ptr_q] <= wr_data_s;
         eofc_mem_q[wr_ptr_q] <= wr_eofc_s & EOFC_MASK;
      end
   end

   assign smiOutReady = out_ready_q;
   assign smiOutEofc  = eofc_mem_q[rd_ptr_q];
   assign smiOutData  = data_mem_q[rd_ptr_q];

endmodule
